// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: a small word FIFO behind a valid/ready port, drained
// one bit per clock onto dout with no idle gap between back-to-back words.
module bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     dout,
    output logic                     dout_valid,
    output logic                     last_bit,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned FC_W  = PTR_W + 1;
    localparam int unsigned BC_W  = $clog2(WIDTH);

    localparam logic [FC_W-1:0] FULL_CNT = FC_W'(DEPTH);
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [FC_W-1:0]  count_q;
    logic [FC_W-1:0]  count_d;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [BC_W-1:0]  bitcnt_q;
    logic [BC_W-1:0]  bitcnt_d;
    logic             dout_d;
    logic             dout_valid_d;
    logic             last_bit_d;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    // Bit that leaves the word first in the configured order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its outgoing bit removed, remaining bits moved toward the exit end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Space is judged on the registered count only, so a same-cycle pop never admits a write.
    assign in_ready   = !rst && (count_q != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr_q];
    assign fifo_count = count_q;

    // Shifter next-state and output decode.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        dout_d       = IDLE_LEVEL;
        dout_valid_d = 1'b0;
        last_bit_d   = 1'b0;
        pop          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop          = 1'b1;
                    dout_d       = first_bit(head);
                    dout_valid_d = 1'b1;
                    shreg_d      = advance(head);
                    bitcnt_d     = LAST_IDX;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bitcnt_q != '0) begin
                    dout_d       = first_bit(shreg_q);
                    dout_valid_d = 1'b1;
                    last_bit_d   = (bitcnt_q == BC_W'(1));
                    shreg_d      = advance(shreg_q);
                    bitcnt_d     = bitcnt_q - BC_W'(1);
                end else if (count_q != '0) begin
                    // Chain straight into the next queued word: no idle bit between words.
                    pop          = 1'b1;
                    dout_d       = first_bit(head);
                    dout_valid_d = 1'b1;
                    shreg_d      = advance(head);
                    bitcnt_d     = LAST_IDX;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy update.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + FC_W'(1);
            2'b01:   count_d = count_q - FC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            last_bit   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            last_bit   <= last_bit_d;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Word storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Upstream feeder for the serial `0110` pattern counter. Accepts parallel words through a valid/ready handshake and buffers them in a small FIFO. Shifts each word out one bit per clock on `dout`, producing the single-bit stream the pattern counter samples on its `din`. Back-to-back words are emitted with no idle gap.

## Interface
- `WIDTH`, 8, data word width in bits (≥2).
- `DEPTH`, 4, FIFO depth in words (power of two, ≥2).
- `MSB_FIRST`, 1, 1 = shift bit `WIDTH-1` first; 0 = bit 0 first.
- `IDLE_LEVEL`, 1'b1, value driven on `dout` when no word is being shifted.

Ports:
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `in_valid` input 1: producer has a word on `in_data`.
- `in_data` input `WIDTH`: word to serialize.
- `in_ready` output 1: FIFO can accept a word this cycle.
- `dout` output 1: serial bit stream (registered).
- `dout_valid` output 1: `dout` carries a data bit (registered).
- `last_bit` output 1: `dout` is the final bit of its word (registered).
- `fifo_count` output `$clog2(DEPTH)+1`: words held in the FIFO, excluding the word in the shifter.

## Operation
- **Reset values (async on `rst`):**
  - FIFO pointers and `fifo_count` = 0.
  - Shifter idle, bit counter = 0.
  - `dout` = `IDLE_LEVEL`; `dout_valid` = 0; `last_bit` = 0; `in_ready` = 0 while `rst` is high.
- **Write:** accepted on a rising edge when `in_valid && in_ready`.
  - `in_ready = !rst && (fifo_count != DEPTH)`, derived from registered count only.
  - A pop in the same cycle does not free space for a write: no write-through when full.
- **Shifter FSM:**
  - IDLE:
    - If `fifo_count != 0`, pop the head word into the shift register.
    - Drive its first bit on `dout` with `dout_valid` = 1, set bit counter = `WIDTH-1`, go to SHIFT.
    - Otherwise drive `dout` = `IDLE_LEVEL`, `dout_valid` = 0.
  - SHIFT, bit counter > 0: present the next bit (order per `MSB_FIRST`) and decrement the counter.
  - SHIFT, counter reaches 0: the bit on `dout` during that cycle has `last_bit` = 1.
  - End of word:
    - At the edge ending the last bit, if `fifo_count != 0`, pop and load the next word immediately. Its first bit appears in the following cycle, with no gap, and the FSM stays in SHIFT.
    - Otherwise go to IDLE and drive `IDLE_LEVEL`.
- **Simultaneous write and pop:** `fifo_count` is unchanged and both pointers advance.
  - Write into an empty FIFO while the shifter is idle: the word enters the FIFO and is popped on the next edge (no bypass path).
- **Pointer arithmetic:** pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `fifo_count` saturates neither way; over- and underflow are prevented by the handshake and pop conditions.
- **Reset mid-word:** the partial word and all FIFO contents are discarded. Output returns to `IDLE_LEVEL` immediately (asynchronously). After release, the first accepted word starts cleanly.

## Timing
- **First-bit latency:** word accepted at edge T with the shifter idle → first bit valid on `dout` from edge T+1 through T+2. Last bit occupies cycle T+`WIDTH`.
- **Throughput:** one bit per clock sustained; one word per `WIDTH` clocks.
- `in_ready` falls in the cycle after the write that makes `fifo_count == DEPTH`. It rises in the cycle after the next pop.
- `dout`, `dout_valid` and `last_bit` are all flop outputs; none is combinational from inputs.

## Test plan
- **Single word, MSB_FIRST=1:** write 8'hB6 at edge T → `dout` = 1,0,1,1,0,1,1,0 on cycles T+1..T+8. `dout_valid` is high exactly for those 8 cycles, `last_bit` is high only at T+8, then `dout` = 1 idle.
- **Back-to-back:** write 8'h0F then 8'hF0 on consecutive edges → 16 contiguous valid bits 0000111111110000 with no idle cycle. `last_bit` is high at the 8th and 16th bits.
- **Full FIFO:** hold `in_valid` high with 6 distinct words while the first is shifting → `fifo_count` reaches 4 and `in_ready` = 0. The 6th word is held until the first pop, and all 6 words are emitted in order with no loss or duplication.
- **Reset mid-word:** assert `rst` on bit 3 of 8'hA5 with 2 words queued → `dout` = 1, `dout_valid` = 0, `fifo_count` = 0 immediately. After release a new 8'h3C serializes correctly from T+1.
- **Integration with the pattern counter** (`dout` → `din`, counter reset released first): send 8'h66 from idle → counter = 2. Then send 8'hFF → counter stays 2.
- **LSB order:** MSB_FIRST=0, write 8'h01 → `dout` sequence 1,0,0,0,0,0,0,0.
